// File: rtl/rcb_led_supervisor_if.sv
// rcb_led_supervisor_if: control inputs and indicator outputs of the LED supervisor.
interface rcb_led_supervisor_if;
  logic enable;
  logic hb_in;
  logic fault;
  logic fault_clr;
  logic led_run;
  logic led_err;
  logic hb_lost;
  logic [1:0] state;
  modport master (output enable, hb_in, fault, fault_clr, input led_run, led_err, hb_lost, state);
  modport slave (input enable, hb_in, fault, fault_clr, output led_run, led_err, hb_lost, state);
endinterface

// File: rtl/rcb_led_supervisor.sv
// rcb_led_supervisor: heartbeat-watchdog FSM driving blinking run/error LEDs.
module rcb_led_supervisor #(
  parameter int PRESCALE = 100,
  parameter int MS_DIV = 1000,
  parameter int HB_TIMEOUT_MS = 500,
  parameter int BLINK_MS = 250
) (
  input logic clk_100m,
  input logic rst_n,
  rcb_led_supervisor_if.slave bus
);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, LOST = 2'b10, FAULT = 2'b11;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int MW = MS_DIV > 1 ? $clog2(MS_DIV) : 1;
  localparam int BW = BLINK_MS > 1 ? $clog2(BLINK_MS) : 1;
  localparam int TW = $clog2(HB_TIMEOUT_MS + 1);
  logic [PW-1:0] pcnt;
  logic [MW-1:0] mcnt;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] hb_timer;
  logic [2:0] sync;
  logic [1:0] state_q, nxt;
  logic blink, led_run, led_err;
  logic tick_us, tick_ms, blink_wrap, blink_n, hb_edge, lost;
  logic timer_clr;
  assign tick_us = pcnt == PW'(PRESCALE - 1);
  assign tick_ms = tick_us && mcnt == MW'(MS_DIV - 1);
  assign blink_wrap = tick_ms && bcnt == BW'(BLINK_MS - 1);
  assign blink_n = blink ^ blink_wrap;
  assign hb_edge = sync[1] ^ sync[2];
  assign lost = hb_timer == TW'(HB_TIMEOUT_MS);
  // Timer is zero outside RUN/HB_LOST and restarts on every RUN entry.
  assign timer_clr = nxt == IDLE || nxt == FAULT || hb_edge || (nxt == RUN && state_q != RUN);
  always_comb begin
    nxt = state_q;
    if (state_q == FAULT)
      nxt = (bus.fault_clr && !bus.fault) ? IDLE : FAULT;
    else if (bus.fault)
      nxt = FAULT;
    else if (!bus.enable)
      nxt = IDLE;
    else
      nxt = state_q == IDLE ? RUN : state_q == RUN ? (lost ? LOST : RUN) : (hb_edge ? RUN : LOST);
  end
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      pcnt <= '0;
      mcnt <= '0;
      bcnt <= '0;
      blink <= 1'b0;
      sync <= '0;
      hb_timer <= '0;
      state_q <= IDLE;
      led_run <= 1'b0;
      led_err <= 1'b0;
    end else begin
      pcnt <= tick_us ? '0 : pcnt + 1'b1;
      mcnt <= tick_ms ? '0 : tick_us ? mcnt + 1'b1 : mcnt;
      bcnt <= blink_wrap ? '0 : tick_ms ? bcnt + 1'b1 : bcnt;
      blink <= blink_n;
      sync <= {sync[1:0], bus.hb_in};
      hb_timer <= timer_clr ? '0 : (tick_ms && !lost) ? hb_timer + 1'b1 : hb_timer;
      state_q <= nxt;
      led_run <= nxt == RUN && blink_n;
      led_err <= nxt == FAULT || (nxt == LOST && blink_n);
    end
  end
  assign bus.state = state_q;
  assign bus.led_run = led_run;
  assign bus.led_err = led_err;
  assign bus.hb_lost = lost;
endmodule

// File: doc/rcb_led_supervisor.md
RCB_LED_SUPERVISOR -- requirements
Module: rcb_led_supervisor

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 100, giving clk_100m cycles per 1 us tick.
REQ-002 The block SHALL have parameter MS_DIV, default 1000, giving 1 us ticks per 1 ms tick.
REQ-003 The block SHALL have parameter HB_TIMEOUT_MS, default 500, giving the number of ms without a heartbeat edge before loss is declared.
REQ-004 The block SHALL have parameter BLINK_MS, default 250, giving the blink half-period in ms.
REQ-005 The block SHALL have port clk_100m, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: synchronous level that requests supervision.
REQ-008 The block SHALL have port hb_in, input, 1 bit: asynchronous toggling heartbeat from the blinker stage; any edge counts.
REQ-009 The block SHALL have port fault, input, 1 bit: synchronous fault level.
REQ-010 The block SHALL have port fault_clr, input, 1 bit: synchronous single-cycle fault acknowledge.
REQ-011 The block SHALL have port led_run, output, 1 bit: registered run indicator.
REQ-012 The block SHALL have port led_err, output, 1 bit: registered error indicator.
REQ-013 The block SHALL have port hb_lost, output, 1 bit: heartbeat-timeout flag.
REQ-014 The block SHALL have port state, output, 2 bits: current FSM state encoding.

Function
REQ-015 The prescaler SHALL count 0..PRESCALE-1 free-running, wrap to 0, and pulse tick_us for exactly one cycle at count PRESCALE-1.
REQ-016 The ms counter SHALL count 0..MS_DIV-1 on tick_us and pulse tick_ms for one cycle when it is at MS_DIV-1 and tick_us is high.
REQ-017 hb_in SHALL pass through a two-flop synchronizer plus a third delay flop; hb_edge = XOR of the last two stages, so edge detection has 3-cycle latency.
REQ-018 hb_timer SHALL clear on hb_edge or on entry to RUN, and otherwise increment on tick_ms, saturating at HB_TIMEOUT_MS.
REQ-019 When hb_edge and tick_ms coincide, the clear SHALL win.
REQ-020 hb_lost SHALL equal (hb_timer == HB_TIMEOUT_MS), decoded from the registered timer; in IDLE and FAULT, hb_timer SHALL be held at 0.
REQ-021 The blink counter SHALL count 0..BLINK_MS-1 on tick_ms and toggle the blink bit at wrap.
REQ-022 The FSM SHALL use encodings IDLE=00, RUN=01, HB_LOST=10, FAULT=11.
REQ-023 Transition priority in IDLE/RUN/HB_LOST SHALL be: fault -> FAULT; else enable=0 -> IDLE; else the state-specific rule.
REQ-024 IDLE SHALL go to RUN when enable=1.
REQ-025 RUN SHALL go to HB_LOST when hb_lost=1.
REQ-026 HB_LOST SHALL go to RUN on hb_edge.
REQ-027 FAULT SHALL ignore enable and hb_edge, and SHALL go to IDLE only when fault_clr=1 and fault=0 in the same cycle; fault_clr while fault=1 SHALL have no effect.
REQ-028 Outputs SHALL be registered from the next-state value, so they change on the same edge as state.
REQ-029 Output values per state SHALL be: IDLE: led_run=0, led_err=0; RUN: led_run=blink, led_err=0; HB_LOST: led_run=0, led_err=blink; FAULT: led_run=0, led_err=1.
REQ-030 fault_clr outside FAULT SHALL be ignored.

Reset
REQ-031 While rst_n=0 at a clock edge, all counters, the synchronizer flops, blink, hb_timer, led_run, led_err and hb_lost SHALL be 0, and state SHALL be IDLE.
REQ-032 Reset asserted mid-operation, in any state, SHALL take effect at the next clk_100m edge with no outstanding tick or transition surviving.
REQ-033 The block SHALL have no asynchronous reset path.

Verification (PRESCALE=10, MS_DIV=10, so 1 ms = 100 cycles; HB_TIMEOUT_MS=5, BLINK_MS=2)
REQ-034 The bench SHALL check: reset released, enable=0 for 1000 cycles -> state=00, led_run=led_err=hb_lost=0; tick_us period 10 cycles, tick_ms period 100 cycles.
REQ-035 The bench SHALL check: enable=1, hb_in toggled every 150 cycles -> state reaches 01 the cycle after enable; hb_lost never asserts; led_run toggles every 200 cycles.
REQ-036 The bench SHALL check: enable=1, hb_in static -> hb_lost and state=10 within 401..503 cycles of entering RUN; led_err blinks at a 200-cycle half-period; one hb_in toggle -> state=01 within 4 cycles, hb_lost=0.
REQ-037 The bench SHALL check: fault=1 in RUN -> state=11, led_err=1 next edge; fault_clr pulsed with fault=1 -> stays 11; fault=0 then fault_clr -> state=00.
REQ-038 The bench SHALL check: fault and enable=0 in the same cycle from RUN -> FAULT; hb_edge coincident with tick_ms at hb_timer=4 -> hb_timer=0, no hb_lost.
REQ-039 The bench SHALL check: rst_n=0 for one cycle while in HB_LOST with led_err=1 -> next edge all outputs 0, state=00.
